// File: rtl/weight_bank_reader.sv
// rtl/weight_bank_reader.sv - multi-bank weight RAM with burst reader, latency-matched valid/last
// Optional stored even parity per word: define WEIGHT_PARITY_EN.
module weight_bank_reader #(
   parameter int DATA_WIDTH   = 16,
   parameter int DEPTH        = 64,
   parameter int NUM_BANKS    = 4,
   parameter int READ_LATENCY = 2,
   localparam int ADDR_WIDTH  = $clog2(DEPTH),
   localparam int BANK_WIDTH  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                            iclk,
   input  logic                            irst,
   input  logic                            wr_en,
   input  logic [BANK_WIDTH-1:0]           wr_bank,
   input  logic [ADDR_WIDTH-1:0]           wr_addr,
   input  logic [DATA_WIDTH-1:0]           wr_data,
   input  logic                            load_done,
   input  logic                            clear,
   input  logic                            rd_start,
   input  logic [ADDR_WIDTH-1:0]           rd_base,
   input  logic [ADDR_WIDTH:0]             rd_len,
   output logic                            loaded,
   output logic                            rd_busy,
   output logic                            dout_valid,
   output logic                            dout_last,
   output logic [NUM_BANKS*DATA_WIDTH-1:0] dout,
   output logic                            err,
   output logic                            par_err
);

`ifdef WEIGHT_PARITY_EN
   localparam int PW = 1;
`else
   localparam int PW = 0;
`endif
   localparam int WW = DATA_WIDTH + PW;
   localparam int CW = $clog2(NUM_BANKS*DEPTH + 1);
   localparam logic [CW-1:0]         FULL    = CW'(NUM_BANKS*DEPTH);
   localparam logic [ADDR_WIDTH:0]   LEN_MAX = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   LEN_ONE = (ADDR_WIDTH+1)'(1);

   typedef enum logic [1:0] {S_EMPTY, S_LOADING, S_LOADED, S_BURST} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           wcnt_q, wcnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [ADDR_WIDTH:0]     rem_q, rem_d;
   logic                    clr_pend_q, clr_pend_d;
   logic                    err_q, err_d;
   logic                    wr_acc, bank_ok, len_ok, last_issue;
   logic [READ_LATENCY-1:0] vld_q, last_q;
   logic [WW-1:0]           wr_word;
   logic [WW-1:0]           lane;
   logic [WW-1:0]           mem [NUM_BANKS][DEPTH];
   logic [NUM_BANKS*WW-1:0] pipe_q [READ_LATENCY];

`ifdef WEIGHT_PARITY_EN
   assign wr_word = {^wr_data, wr_data};
`else
   assign wr_word = wr_data;
`endif

   always_comb begin
      bank_ok    = (int'(wr_bank) < NUM_BANKS);
      len_ok     = (rd_len != '0) && (rd_len <= LEN_MAX);
      last_issue = (state_q == S_BURST) && (rem_q == LEN_ONE);
      wr_acc     = wr_en && bank_ok && (state_q != S_BURST);
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      clr_pend_d = clr_pend_q;
      err_d      = wr_en && !wr_acc;
      if (wr_acc && wcnt_q != FULL) wcnt_d = wcnt_q + 1'b1;
      case (state_q)
         S_EMPTY:   if (wr_acc) state_d = S_LOADING;
         S_LOADING: if (load_done || wcnt_d == FULL) state_d = S_LOADED;
         S_LOADED:  state_d = S_LOADED;
         S_BURST: begin
            addr_d = addr_q + 1'b1;
            rem_d  = rem_q - 1'b1;
            if (clear) clr_pend_d = 1'b1;
            if (last_issue) begin
               clr_pend_d = 1'b0;
               if (clr_pend_q || clear) begin
                  state_d = S_EMPTY;
                  wcnt_d  = '0;
               end else begin
                  state_d = S_LOADED;
               end
            end
         end
         default:   state_d = S_EMPTY;
      endcase
      if (clear && state_q != S_BURST) begin
         state_d = S_EMPTY;
         wcnt_d  = '0;
      end
      // A start during the final issue cycle chains directly, keeping dout gap-free.
      if (rd_start) begin
         if (len_ok && !clear && (state_q == S_LOADED || (last_issue && !clr_pend_q))) begin
            state_d = S_BURST;
            addr_d  = rd_base;
            rem_d   = rd_len;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         state_q    <= S_EMPTY;
         wcnt_q     <= '0;
         addr_q     <= '0;
         rem_q      <= '0;
         clr_pend_q <= 1'b0;
         err_q      <= 1'b0;
         vld_q      <= '0;
         last_q     <= '0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         clr_pend_q <= clr_pend_d;
         err_q      <= err_d;
         vld_q[0]   <= (state_q == S_BURST);
         last_q[0]  <= last_issue;
         for (int s = 1; s < READ_LATENCY; s++) begin
            vld_q[s]  <= vld_q[s-1];
            last_q[s] <= last_q[s-1];
         end
      end
   end

   // Storage and data pipeline carry no reset; outputs are masked by the valid pipe.
   always_ff @(posedge iclk) begin
      if (wr_acc) mem[wr_bank][wr_addr] <= wr_word;
      for (int b = 0; b < NUM_BANKS; b++) pipe_q[0][b*WW +: WW] <= mem[b][addr_q];
      for (int s = 1; s < READ_LATENCY; s++) pipe_q[s] <= pipe_q[s-1];
   end

   always_comb begin
      dout    = '0;
      par_err = 1'b0;
      lane    = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         lane = pipe_q[READ_LATENCY-1][b*WW +: WW];
         if (vld_q[READ_LATENCY-1]) begin
            dout[b*DATA_WIDTH +: DATA_WIDTH] = lane[DATA_WIDTH-1:0];
`ifdef WEIGHT_PARITY_EN
            par_err = par_err | (^lane);
`endif
         end
      end
   end

   assign loaded     = (state_q == S_LOADED) || (state_q == S_BURST);
   assign rd_busy    = (state_q == S_BURST);
   assign err        = err_q;
   assign dout_valid = vld_q[READ_LATENCY-1];
   assign dout_last  = last_q[READ_LATENCY-1];

endmodule
